vga_timing_gen: RTL and testbench

//   Raster timing source for the VGA pipeline: free-running horizontal/vertical

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_gen_wrap_counter.sv | 24 ++
 rtl/vga_timing_gen.sv | 91 +++++++++
 tb/tb_vga_timing_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing and helpers shared by the VGA timing blocks.
// Pure constants and functions: no logic, no latency.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [DEF_CW-1:0] coord_t;

    // Sync pulse occupies [active+fp, active+fp+sync) of each axis.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    localparam int DEF_H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
    localparam int DEF_H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
    localparam int DEF_V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
    localparam int DEF_V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-MOD up counter; wrap is a combinational flag for the increment that returns to 0.
// Holds while en is low; synchronous active-high reset to 0.
module wrap_counter #(
    parameter int W   = 10,
    parameter int MOD = 800
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(MOD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: h/v counters decoded into registered coordinates, active flag, syncs, strobes.
// One cycle from count to outputs; en low freezes everything and clears the strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = DEF_CW
) (
    input  logic          pixelClk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] xCor,
    output logic [CW-1:0] yCor,
    output logic          dValid,
    output logic          hSync,
    output logic          vSync,
    output logic          frameStart,
    output logic          lineStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CW-1:0] HS_END   = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CW-1:0] VS_START = CW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CW-1:0] VS_END   = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;

    wrap_counter #(.W(CW), .MOD(H_TOTAL)) u_h_cnt (
        .clk   (pixelClk),
        .rst   (rst),
        .en    (en),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.W(CW), .MOD(V_TOTAL)) u_v_cnt (
        .clk   (pixelClk),
        .rst   (rst),
        .en    (en && h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    logic h_in_sync;
    logic v_in_sync;

    assign h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // Every output is taken from the same h_cnt/v_cnt snapshot so they stay coherent.
    always_ff @(posedge pixelClk) begin
        if (rst) begin
            xCor       <= '0;
            yCor       <= '0;
            dValid     <= 1'b0;
            hSync      <= ~H_POL;
            vSync      <= ~V_POL;
            frameStart <= 1'b0;
            lineStart  <= 1'b0;
        end else if (en) begin
            xCor       <= h_cnt;
            yCor       <= v_cnt;
            dValid     <= (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
            hSync      <= h_in_sync ? H_POL : ~H_POL;
            vSync      <= v_in_sync ? V_POL : ~V_POL;
            frameStart <= (h_cnt == '0) && (v_cnt == '0);
            lineStart  <= (h_cnt == '0);
        end else begin
            frameStart <= 1'b0;
            lineStart  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size DUT for reset/line/freeze/reset-mid-line, and a shrunken
// DUT (15x10 raster, active-high hSync) for whole-frame and wrap checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    logic [9:0] xb, yb;
    logic       dvb, hsb, vsb, fsb, lsb;
    logic [3:0] xs, ys;
    logic       dvs, hss, vss, fss, lss;

    vga_timing_gen u_big (
        .pixelClk   (clk),
        .rst        (rst),
        .en         (en),
        .xCor       (xb),
        .yCor       (yb),
        .dValid     (dvb),
        .hSync      (hsb),
        .vSync      (vsb),
        .frameStart (fsb),
        .lineStart  (lsb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .CW(4)
    ) u_small (
        .pixelClk   (clk),
        .rst        (rst),
        .en         (en),
        .xCor       (xs),
        .yCor       (ys),
        .dValid     (dvs),
        .hSync      (hss),
        .vSync      (vss),
        .frameStart (fss),
        .lineStart  (lss)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int inv_err = 0;
    bit inv_on  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (inv_on) begin
            if (dvb !== ((xb < 10'd640) && (yb < 10'd480))) inv_err++;
            if (dvs !== ((xs < 4'd8) && (ys < 4'd6)))       inv_err++;
        end
        if (fsb && !lsb) inv_err++;
        if (fss && !lss) inv_err++;
    end

    initial begin
        int dv_cnt, hs_low, hs_first, hs_last, ls_cnt;
        int frz_bad, frz_strobe;
        int fs_cnt, fs_gap, vs_low, vs_first, vs_last, hs_high, hs_xf, hs_xl;
        bit pend_wrap, wrap_done;

        // Reset state
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) tick();
        check("rst_x",      xb,  0);
        check("rst_y",      yb,  0);
        check("rst_dvalid", dvb, 0);
        check("rst_fs",     fsb, 0);
        check("rst_ls",     lsb, 0);
        check("rst_hsync",  hsb, 1);
        check("rst_vsync",  vsb, 1);
        check("rst_small_hsync", hss, 0);

        rst = 1'b0;
        tick();
        check("first_x",      xb,  0);
        check("first_y",      yb,  0);
        check("first_dvalid", dvb, 1);
        check("first_fs",     fsb, 1);
        check("first_ls",     lsb, 1);
        check("first_hsync",  hsb, 1);
        inv_on = 1'b1;

        // One full line on the 640x480 instance
        dv_cnt = 0; hs_low = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (dvb) dv_cnt++;
            if (!hsb) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(xb);
                hs_last = int'(xb);
            end
            if (lsb) ls_cnt++;
            tick();
        end
        check("line_dvalid_cnt", dv_cnt,   640);
        check("line_hs_low",     hs_low,   96);
        check("line_hs_first",   hs_first, 656);
        check("line_hs_last",    hs_last,  751);
        check("line_ls_cnt",     ls_cnt,   1);
        check("line1_x",  xb,  0);
        check("line1_y",  yb,  1);
        check("line1_ls", lsb, 1);
        check("line1_fs", fsb, 0);

        // Freeze at x=300
        for (int i = 0; i < 1000 && xb != 10'd300; i++) tick();
        check("reach_300", xb, 300);
        en = 1'b0;
        frz_bad = 0; frz_strobe = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (xb != 10'd300 || yb != 10'd1 || !dvb || !hsb || !vsb) frz_bad++;
            if (lsb || fsb) frz_strobe++;
        end
        check("freeze_hold",    frz_bad,    0);
        check("freeze_strobes", frz_strobe, 0);
        en = 1'b1;
        tick();
        check("resume_x",  xb,  301);
        check("resume_ls", lsb, 0);

        // Reset mid-line at (400,1), en low during reset
        for (int i = 0; i < 1000 && xb != 10'd400; i++) tick();
        check("reach_400", xb, 400);
        inv_on = 1'b0;
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check("mrst_x",      xb,  0);
        check("mrst_y",      yb,  0);
        check("mrst_dvalid", dvb, 0);
        check("mrst_ls",     lsb, 0);
        check("mrst_hsync",  hsb, 1);
        check("mrst_vsync",  vsb, 1);
        tick();
        rst = 1'b0;
        en  = 1'b1;
        tick();
        check("restart_x",  xb,  0);
        check("restart_y",  yb,  0);
        check("restart_fs", fsb, 1);
        check("restart_ls", lsb, 1);
        check("restart_dv", dvb, 1);
        inv_on = 1'b1;

        // Strobes clear while frozen and do not re-fire on resume
        en = 1'b0;
        tick();
        check("frz0_fs", fsb, 0);
        check("frz0_ls", lsb, 0);
        check("frz0_x",  xb,  0);
        check("frz0_dv", dvb, 1);
        tick();
        en = 1'b1;
        tick();
        check("frz0_resume_x",  xb,  1);
        check("frz0_resume_fs", fsb, 0);
        check("frz0_resume_ls", lsb, 0);

        // Whole frames on the 15x10 instance
        for (int i = 0; i < 200 && !fss; i++) tick();
        check("small_sof", fss, 1);
        fs_cnt = 0; fs_gap = -1; dv_cnt = 0; vs_low = 0; vs_first = -1; vs_last = -1;
        hs_high = 0; hs_xf = -1; hs_xl = -1;
        pend_wrap = 1'b0; wrap_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (pend_wrap) begin
                check("wrap_x",     xs,  0);
                check("wrap_y",     ys,  0);
                check("wrap_fs",    fss, 1);
                check("wrap_hsync", hss, 0);
                check("wrap_vsync", vss, 1);
                pend_wrap = 1'b0;
                wrap_done = 1'b1;
            end
            if (fss) begin
                fs_cnt++;
                if (fs_cnt == 2) fs_gap = i;
            end
            if (i < 150) begin
                if (dvs) dv_cnt++;
                if (!vss) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = int'(ys);
                    vs_last = int'(ys);
                end
                if (hss) begin
                    hs_high++;
                    if (hs_xf < 0) hs_xf = int'(xs);
                    hs_xl = int'(xs);
                end
            end
            if (!wrap_done && xs == 4'd14 && ys == 4'd9) pend_wrap = 1'b1;
            tick();
        end
        check("small_wrap_seen", wrap_done, 1);
        check("small_fs_cnt",    fs_cnt,    2);
        check("small_fs_period", fs_gap,    150);
        check("small_dvalid",    dv_cnt,    48);
        check("small_vs_low",    vs_low,    30);
        check("small_vs_first",  vs_first,  7);
        check("small_vs_last",   vs_last,   8);
        check("small_hs_high",   hs_high,   30);
        check("small_hs_xfirst", hs_xf,     10);
        check("small_hs_xlast",  hs_xl,     12);

        check("invariants", inv_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
